grade_sched: RTL and testbench
==============================

Name: grade_sched

Overview:
- Sequencer that time-shares one weighted-average row engine across the 4 output grades of a sample. The row engine is external and fully pipelined: 4 multipliers, a 4-input adder and a divider.
- Holds the 16 weights in a local bank. Accepts one sample (a,b,c,d) per transaction, issues rows 0..3 on consecutive cycles, collects the 4 results and presents them as g1..g4 with a valid/ready handshake.
- Sits between the sample source / config bus and the shared row engine. Replaces four parallel row datapaths with one.

Parameters:
- W, 19, data width (signed two's complement) of samples, weights and results.
- ENG_LAT, 3, engine latency in cycles from eng_valid to eng_g valid; legal range 1..15.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  sample offered.
- in_ready  out  1  sample accepted when in_valid&in_ready.
- in_a, in_b, in_c, in_d  in  W each  sample operands (signed).
- cfg_we  in  1  weight write strobe.
- cfg_addr  in  4  weight index = row*4+col; col 0..3 = a..d.
- cfg_wdata  in  W  weight value (signed).
- cfg_err  out  1  one-cycle pulse: write rejected (block not IDLE).
- eng_valid  out  1  operands on eng_* are a new row issue.
- eng_a, eng_b, eng_c, eng_d  out  W each  latched sample operands.
- eng_wa, eng_wb, eng_wc, eng_wd  out  W each  weights of the issued row.
- eng_g  in  W  engine result, valid ENG_LAT cycles after the matching issue.
- out_valid  out  1  g1..g4 valid.
- out_ready  in  1  consumer accepts.
- g1, g2, g3, g4  out  W each  grade results for rows 0..3.
- err_divz  out  4  per-row zero-weight-sum flag (see Optional Feature).
- busy  out  1  state != IDLE.

Behaviour:
- Reset (asynchronous, immediate, any state): state=IDLE, all weights=0, g1..g4=0, err_divz=0, tag pipe cleared. Outputs: out_valid=0, eng_valid=0, eng_* operands=0, cfg_err=0, in_ready=1.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: in_ready=1. On in_valid, latch in_a..in_d and go to ISSUE with row counter r=0.
- ISSUE: eng_valid=1 and eng_w* = bank[r*4+0..3] for 4 consecutive cycles, r=0..3. After r=3 go to DRAIN.
- Tag pipe: ENG_LAT-deep shift register of {valid,row}. At issue, the tag enters. When a tag exits, eng_g is registered into g(row+1).
- DRAIN: wait until the row-3 tag exits and is captured, then go to DONE.
- DONE: out_valid=1 and g1..g4 are held stable until out_ready. On out_valid&out_ready, go to IDLE. in_ready is 1 in the following cycle.
- Latency: with the accept at cycle 0, rows are issued at cycles 1..4 and row r is captured at the end of cycle 1+r+ENG_LAT. out_valid first rises at cycle 5+ENG_LAT (8 for ENG_LAT=3).
- Throughput: one sample per 6+ENG_LAT cycles when out_ready is held at 1.
- in_ready=0 in ISSUE, DRAIN and DONE. There is no overlap between samples.
- eng_valid=0 outside ISSUE. eng_a..eng_d keep their last latched values.
- Weight writes: accepted only in IDLE, taking effect at the next edge. A cfg_we in IDLE coincident with an in_valid accept writes the bank before row 0 is issued, so the new weight is used. A cfg_we in any other state is dropped and cfg_err pulses high for 1 cycle.
- Arithmetic is performed entirely by the engine. The controller never modifies eng_g, except when the optional feature forces a row to zero.

Optional Feature:
- Macro: GRADE_DIVZ_CHECK_EN.
- Enabled: at issue of row r, compute the W+2-bit sum of the row's 4 weights. If the sum is 0, set err_divz[r], and at capture force g(r+1)=0 regardless of eng_g. err_divz is cleared on the next in_valid accept and held through DONE.
- Disabled: err_divz is tied to 4'b0 and eng_g is always passed through unchanged.

Decomposition:
- Package grade_pkg: constants GRADE_W=19, GRADE_ROWS=4, GRADE_COLS=4; state enum {IDLE, ISSUE, DRAIN, DONE}; row index type (2 bits).
- One sub-module: grade_wbank.
  - 16xW register file with asynchronous reset to 0.
  - One write port gated by IDLE.
  - One combinational read port returning a whole row (4 weights).

Test Plan:
- Reset then idle: out_valid=0, eng_valid=0, in_ready=1, busy=0, g1..g4=0.
- Basic transaction, ENG_LAT=3 behavioural engine = (sum of x*w)/(sum of w).
  - Row0 weights 1,1,1,1; rows 1..3 weights 1,0,0,0 / 0,1,0,0 / 0,0,0,1; sample 4,8,12,16.
  - Expect g1=10, g2=4, g3=8, g4=16, with out_valid at cycle 8 after the accept.
- Backpressure: hold out_ready=0 for 5 cycles.
  - g1..g4 remain stable and out_valid remains 1; in_ready=0 throughout.
  - Release out_ready: IDLE and in_ready=1 on the next cycle.
- Config collision: cfg_we to addr 5 during ISSUE. cfg_err pulses once, bank[5] is unchanged and results match the old weights.
- Async reset asserted in DRAIN: outputs clear immediately without a clock edge. After release, a new transaction with rewritten weights produces correct results and no stale tag capture.
- With GRADE_DIVZ_CHECK_EN and row-2 weights 3,-3,0,0: err_divz=4'b0100, g3=0, and the other rows are correct. Without the macro, err_divz=0.

Source files
------------

// File: rtl/grade_pkg.sv
// Shared types and constants for the grade sequencer.
package grade_pkg;

  localparam int GRADE_W    = 19;
  localparam int GRADE_ROWS = 4;
  localparam int GRADE_COLS = 4;
  localparam int GRADE_NW   = GRADE_ROWS * GRADE_COLS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef logic [1:0] row_t;

endpackage

// File: rtl/grade_wbank.sv
// 16-entry weight register file: one IDLE-gated write port, one
// combinational read port returning a whole row of four weights.
module grade_wbank
  import grade_pkg::*;
#(
  parameter int W = GRADE_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                idle,
  input  logic                we,
  input  logic [3:0]          waddr,
  input  logic signed [W-1:0] wdata,
  input  row_t                rrow,
  output logic signed [W-1:0] rw0,
  output logic signed [W-1:0] rw1,
  output logic signed [W-1:0] rw2,
  output logic signed [W-1:0] rw3
);

  logic signed [W-1:0] mem [GRADE_NW];

  // Weight storage; writes land only while the sequencer is idle.
  // NOTE: this is a small flop array, not a RAM macro, so every entry
  // gets a reset value; a RAM-inferred memory would have no reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < GRADE_NW; i++) mem[i] <= '0;
    end else if (we && idle) begin
      mem[waddr] <= wdata;
    end
  end

  assign rw0 = mem[{rrow, 2'd0}];
  assign rw1 = mem[{rrow, 2'd1}];
  assign rw2 = mem[{rrow, 2'd2}];
  assign rw3 = mem[{rrow, 2'd3}];

endmodule

// File: rtl/grade_sched.sv
// Time-shares one external pipelined weighted-average row engine across
// the four grade rows of a sample. ENG_LAT legal range is 1..15.
// Optional zero-weight-sum detection: define GRADE_DIVZ_CHECK_EN.
module grade_sched
  import grade_pkg::*;
#(
  parameter int W       = GRADE_W,
  parameter int ENG_LAT = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] in_a,
  input  logic signed [W-1:0] in_b,
  input  logic signed [W-1:0] in_c,
  input  logic signed [W-1:0] in_d,
  input  logic                cfg_we,
  input  logic [3:0]          cfg_addr,
  input  logic signed [W-1:0] cfg_wdata,
  output logic                cfg_err,
  output logic                eng_valid,
  output logic signed [W-1:0] eng_a,
  output logic signed [W-1:0] eng_b,
  output logic signed [W-1:0] eng_c,
  output logic signed [W-1:0] eng_d,
  output logic signed [W-1:0] eng_wa,
  output logic signed [W-1:0] eng_wb,
  output logic signed [W-1:0] eng_wc,
  output logic signed [W-1:0] eng_wd,
  input  logic signed [W-1:0] eng_g,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] g1,
  output logic signed [W-1:0] g2,
  output logic signed [W-1:0] g3,
  output logic signed [W-1:0] g4,
  output logic [3:0]          err_divz,
  output logic                busy
);

  state_t state, state_nxt;
  row_t   r;

  logic [ENG_LAT-1:0] tag_v;
  row_t [ENG_LAT-1:0] tag_row;
  logic               tag_out_v;
  row_t               tag_out_row;
  logic signed [W-1:0] cap_val;
  logic               accept;

  assign accept      = in_valid && in_ready;
  assign tag_out_v   = tag_v[ENG_LAT-1];
  assign tag_out_row = tag_row[ENG_LAT-1];

  grade_wbank #(.W(W)) u_wbank (
    .clk   (clk),
    .rst   (rst),
    .idle  (state == IDLE),
    .we    (cfg_we),
    .waddr (cfg_addr),
    .wdata (cfg_wdata),
    .rrow  (r),
    .rw0   (eng_wa),
    .rw1   (eng_wb),
    .rw2   (eng_wc),
    .rw3   (eng_wd)
  );

  // State register.
  // NOTE: every clocked block uses non-blocking assignments so all flops
  // update together from pre-edge values, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: issue four rows, drain until row 3 is captured, hold.
  // NOTE: state_nxt is defaulted before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (in_valid) state_nxt = ISSUE;
      ISSUE: if (r == 2'd3) state_nxt = DRAIN;
      DRAIN: if (tag_out_v && tag_out_row == 2'd3) state_nxt = DONE;
      DONE:  if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the current state.
  always_comb begin
    in_ready  = 1'b0;
    eng_valid = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE:  begin in_ready = 1'b1; busy = 1'b0; end
      ISSUE: eng_valid = 1'b1;
      DRAIN: ;
      DONE:  out_valid = 1'b1;
      default: ;
    endcase
  end

  // Row counter: steps through rows while issuing, parked at 0 otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 r <= '0;
    else if (state == ISSUE) r <= r + 2'd1;
    else                     r <= '0;
  end

  // Sample operands are captured on accept and held for all four issues.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eng_a <= '0;
      eng_b <= '0;
      eng_c <= '0;
      eng_d <= '0;
    end else if (accept) begin
      eng_a <= in_a;
      eng_b <= in_b;
      eng_c <= in_c;
      eng_d <= in_d;
    end
  end

  // Tag pipe tracks which row's result appears on eng_g, ENG_LAT cycles on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_v   <= '0;
      tag_row <= '0;
    end else begin
      tag_v[0]   <= eng_valid;
      tag_row[0] <= r;
      for (int i = 1; i < ENG_LAT; i++) begin
        tag_v[i]   <= tag_v[i-1];
        tag_row[i] <= tag_row[i-1];
      end
    end
  end

  // Result capture: the exiting tag steers eng_g into its grade register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g1 <= '0;
      g2 <= '0;
      g3 <= '0;
      g4 <= '0;
    end else if (tag_out_v) begin
      case (tag_out_row)
        2'd0: g1 <= cap_val;
        2'd1: g2 <= cap_val;
        2'd2: g3 <= cap_val;
        2'd3: g4 <= cap_val;
        default: ;
      endcase
    end
  end

  // Config writes outside IDLE are dropped and flagged for one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cfg_err <= 1'b0;
    else     cfg_err <= cfg_we && (state != IDLE);
  end

`ifdef GRADE_DIVZ_CHECK_EN
  logic signed [W+1:0] row_sum;

  // Weight sum of the row being issued, widened so it cannot overflow.
  assign row_sum = {{2{eng_wa[W-1]}}, eng_wa} + {{2{eng_wb[W-1]}}, eng_wb}
                 + {{2{eng_wc[W-1]}}, eng_wc} + {{2{eng_wd[W-1]}}, eng_wd};

  // Per-row zero-sum flags: cleared on a new sample, set at issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          err_divz <= '0;
    else if (accept)                  err_divz <= '0;
    else if (eng_valid && row_sum == '0) err_divz[r] <= 1'b1;
  end

  // A flagged row is forced to zero instead of taking the engine result.
  always_comb begin
    cap_val = eng_g;
    if (err_divz[tag_out_row]) cap_val = '0;
  end
`else
  assign err_divz = 4'b0;
  assign cap_val  = eng_g;
`endif

endmodule

// File: tb/tb_grade_sched.sv
// Self-checking bench for grade_sched with a behavioural ENG_LAT=3 row
// engine computing (sum x*w)/(sum w).
module tb_grade_sched;

  localparam int W       = 19;
  localparam int ENG_LAT = 3;
  localparam int JUNK    = 12345;  // engine output when the weight sum is 0

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid, in_ready;
  logic signed [W-1:0] in_a, in_b, in_c, in_d;
  logic                cfg_we;
  logic [3:0]          cfg_addr;
  logic signed [W-1:0] cfg_wdata;
  logic                cfg_err;
  logic                eng_valid;
  logic signed [W-1:0] eng_a, eng_b, eng_c, eng_d;
  logic signed [W-1:0] eng_wa, eng_wb, eng_wc, eng_wd;
  logic signed [W-1:0] eng_g;
  logic                out_valid, out_ready;
  logic signed [W-1:0] g1, g2, g3, g4;
  logic [3:0]          err_divz;
  logic                busy;

  grade_sched #(.W(W), .ENG_LAT(ENG_LAT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_err(cfg_err),
    .eng_valid(eng_valid),
    .eng_a(eng_a), .eng_b(eng_b), .eng_c(eng_c), .eng_d(eng_d),
    .eng_wa(eng_wa), .eng_wb(eng_wb), .eng_wc(eng_wc), .eng_wd(eng_wd),
    .eng_g(eng_g),
    .out_valid(out_valid), .out_ready(out_ready),
    .g1(g1), .g2(g2), .g3(g3), .g4(g4),
    .err_divz(err_divz), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural row engine.
  function automatic logic signed [W-1:0] eng_model(
    input logic signed [W-1:0] a, b, c, d, wa, wb, wc, wd);
    longint num, den;
    num = longint'(a) * longint'(wa) + longint'(b) * longint'(wb)
        + longint'(c) * longint'(wc) + longint'(d) * longint'(wd);
    den = longint'(wa) + longint'(wb) + longint'(wc) + longint'(wd);
    if (den == 0) return W'(JUNK);
    return W'(num / den);
  endfunction

  logic signed [W-1:0] eng_pipe [ENG_LAT];
  always @(posedge clk) begin
    eng_pipe[0] <= eng_valid ? eng_model(eng_a, eng_b, eng_c, eng_d,
                                         eng_wa, eng_wb, eng_wc, eng_wd) : '0;
    for (int i = 1; i < ENG_LAT; i++) eng_pipe[i] <= eng_pipe[i-1];
  end
  assign eng_g = eng_pipe[ENG_LAT-1];

  // Vector table.
  typedef struct packed {
    logic [15:0][7:0] w;
    int a, b, c, d;
    int e1, e2, e3, e4;
    logic [3:0] divz;
  } vec_t;

  vec_t vecs [4];
  int checks = 0;
  int errors = 0;
  int cyc, nvalid, irhi;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_row(input int v, input int row, input int w0, w1, w2, w3);
    vecs[v].w[row*4+0] = 8'(w0);
    vecs[v].w[row*4+1] = 8'(w1);
    vecs[v].w[row*4+2] = 8'(w2);
    vecs[v].w[row*4+3] = 8'(w3);
  endtask

  task automatic set_vec(input int v, input int a, b, c, d,
                         input int e1, e2, e3, e4, input logic [3:0] divz);
    vecs[v].a = a; vecs[v].b = b; vecs[v].c = c; vecs[v].d = d;
    vecs[v].e1 = e1; vecs[v].e2 = e2; vecs[v].e3 = e3; vecs[v].e4 = e4;
    vecs[v].divz = divz;
  endtask

  // Writes all 16 weights of a vector; called at a negedge in IDLE.
  task automatic load_weights(input int v);
    for (int i = 0; i < 16; i++) begin
      cfg_we    = 1'b1;
      cfg_addr  = 4'(i);
      cfg_wdata = W'($signed(vecs[v].w[i]));
      @(negedge clk);
    end
    cfg_we = 1'b0;
  endtask

  // Offers a sample at the current negedge; returns at the cycle-1 negedge.
  task automatic start_txn(input int a, b, c, d);
    in_a = W'(a); in_b = W'(b); in_c = W'(c); in_d = W'(d);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    cyc    = 1;
    nvalid = eng_valid ? 1 : 0;
    irhi   = in_ready ? 1 : 0;
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if (eng_valid) nvalid++;
    if (in_ready && !out_valid) irhi++;
  endtask

  task automatic wait_done();
    while (!out_valid && cyc < 100) step();
  endtask

  task automatic check_results(input string tag, input int e1, e2, e3, e4,
                               input logic [3:0] divz);
    check({tag, " latency"}, cyc, 5 + ENG_LAT);
    check({tag, " issue cycles"}, nvalid, 4);
    check({tag, " in_ready low while busy"}, irhi, 0);
    check({tag, " g1"}, g1, e1);
    check({tag, " g2"}, g2, e2);
    check({tag, " g3"}, g3, e3);
    check({tag, " g4"}, g4, e4);
    check({tag, " err_divz"}, err_divz, divz);
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " out_valid after accept"}, out_valid, 0);
    check({tag, " in_ready after accept"}, in_ready, 1);
    check({tag, " busy after accept"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Basic: row means and single-column picks.
    vecs[0] = '0;
    set_row(0, 0, 1, 1, 1, 1); set_row(0, 1, 1, 0, 0, 0);
    set_row(0, 2, 0, 1, 0, 0); set_row(0, 3, 0, 0, 0, 1);
    set_vec(0, 4, 8, 12, 16, 10, 4, 8, 16, 4'b0000);
    // Signed operands, truncating division, negative weight sum.
    vecs[1] = '0;
    set_row(1, 0, 2, 0, 0, 2); set_row(1, 1, 0, 0, 3, 0);
    set_row(1, 2, 1, 2, 3, 4); set_row(1, 3, -1, 0, 0, 0);
    set_vec(1, -6, 5, 7, 10, 2, 7, 6, -6, 4'b0000);
    // Row 2 weight sum is zero.
    vecs[2] = '0;
    set_row(2, 0, 1, 1, 1, 1); set_row(2, 1, 0, 0, 0, 5);
    set_row(2, 2, 3, -3, 0, 0); set_row(2, 3, 0, 2, 2, 0);
`ifdef GRADE_DIVZ_CHECK_EN
    set_vec(2, 100, 200, 300, 400, 250, 400, 0, 250, 4'b0100);
`else
    set_vec(2, 100, 200, 300, 400, 250, 400, JUNK, 250, 4'b0000);
`endif
    // Full-scale operands.
    vecs[3] = '0;
    set_row(3, 0, 1, 0, 0, 0); set_row(3, 1, 0, 1, 0, 0);
    set_row(3, 2, 0, 0, 1, 1); set_row(3, 3, 0, 0, 0, -1);
    set_vec(3, 262143, -262144, 100, -100, 262143, -262144, 0, -100, 4'b0000);

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; cfg_we = 1'b0;
    cfg_addr = '0; cfg_wdata = '0;
    in_a = '0; in_b = '0; in_c = '0; in_d = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("reset out_valid", out_valid, 0);
    check("reset eng_valid", eng_valid, 0);
    check("reset in_ready", in_ready, 1);
    check("reset busy", busy, 0);
    check("reset cfg_err", cfg_err, 0);
    check("reset err_divz", err_divz, 0);
    check("reset g1", g1, 0);
    check("reset g4", g4, 0);
    check("reset eng_a", eng_a, 0);

    for (int v = 0; v < 4; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      load_weights(v);
      start_txn(vecs[v].a, vecs[v].b, vecs[v].c, vecs[v].d);
      wait_done();
      check_results(tag, vecs[v].e1, vecs[v].e2, vecs[v].e3, vecs[v].e4, vecs[v].divz);
      if (v == 0) begin
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check("backpressure out_valid", out_valid, 1);
          check("backpressure in_ready", in_ready, 0);
          check("backpressure g1", g1, 10);
          check("backpressure g2", g2, 4);
          check("backpressure g3", g3, 8);
          check("backpressure g4", g4, 16);
        end
      end
      consume(tag);
    end

    // Weight write coincident with accept is used by row 0.
    load_weights(0);
    cfg_we = 1'b1; cfg_addr = 4'd0; cfg_wdata = W'(5);
    start_txn(4, 8, 12, 16);
    cfg_we = 1'b0;
    check("coincident cfg_err", cfg_err, 0);
    wait_done();
    check_results("coincident", 7, 4, 8, 16, 4'b0000);
    consume("coincident");
    cfg_we = 1'b1; cfg_addr = 4'd0; cfg_wdata = W'(1);
    @(negedge clk);
    cfg_we = 1'b0;

    // Write during ISSUE is dropped and flagged once.
    start_txn(4, 8, 12, 16);
    cfg_we = 1'b1; cfg_addr = 4'd5; cfg_wdata = W'(77);
    step();
    cfg_we = 1'b0;
    check("collision cfg_err pulse", cfg_err, 1);
    step();
    check("collision cfg_err cleared", cfg_err, 0);
    wait_done();
    check_results("collision", 10, 4, 8, 16, 4'b0000);
    consume("collision");

    // Asynchronous reset in DRAIN.
    start_txn(4, 8, 12, 16);
    repeat (4) step();
    check("drain busy", busy, 1);
    check("drain eng_valid", eng_valid, 0);
    #2 rst = 1'b1;
    #1;
    check("async rst busy", busy, 0);
    check("async rst in_ready", in_ready, 1);
    check("async rst out_valid", out_valid, 0);
    check("async rst g1", g1, 0);
    check("async rst eng_a", eng_a, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("post rst no stale g1", g1, 0);
    check("post rst no stale g2", g2, 0);
    check("post rst no stale g3", g3, 0);
    check("post rst no stale g4", g4, 0);
    check("post rst out_valid", out_valid, 0);
    load_weights(1);
    start_txn(vecs[1].a, vecs[1].b, vecs[1].c, vecs[1].d);
    wait_done();
    check_results("post rst", vecs[1].e1, vecs[1].e2, vecs[1].e3, vecs[1].e4, vecs[1].divz);
    consume("post rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
